fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port npc, input, 32, next-PC from the NPC block.
REQ-004 SHALL have port stall, input, 1, hazard stall from the D-stage hazard unit.
REQ-005 SHALL have port IntReq, input, 1, exception/interrupt request from CP0.
REQ-006 SHALL have port D_eret, input, 1, D-stage instruction is eret.
REQ-007 SHALL have port D_is_branch, input, 1, D-stage instruction is a branch or jump.
REQ-008 SHALL have port IM_instr, input, 32, instruction word read combinationally from IM at PC.
REQ-009 SHALL have port PC, output, 32, current F-stage PC, also the IM address.
REQ-010 SHALL have port D_PC, output, 32, F/D register PC.
REQ-011 SHALL have port D_instr, output, 32, F/D register instruction.
REQ-012 SHALL have port D_ExcCode, output, 5, F/D register fetch exception code (0 = none).
REQ-013 SHALL have port D_BD, output, 1, F/D register branch-delay-slot flag.

Function
REQ-014 SHALL hold PC in a register, priority per edge: reset > IntReq > stall > normal.
- reset low: PC <= 0x0000_3000.
- IntReq: PC <= 0x0000_4180, regardless of stall.
- stall, no IntReq: PC holds.
- otherwise: PC <= npc.
REQ-015 SHALL flag a fetch fault (AdEL, ExcCode 4) when PC[1:0] != 0 or PC < 0x0000_3000 or PC > 0x0000_6FFC.
- Fetch fault: instruction captured SHALL be 0x0000_0000 (nop), not IM_instr.
REQ-016 SHALL derive F_BD = D_is_branch, sampled in the same cycle as the F/D capture.
REQ-017 SHALL update F/D registers per edge, priority: reset > IntReq > stall > D_eret > normal.
- reset low or IntReq (flush): D_instr <= 0, D_ExcCode <= 0, D_BD <= 0, D_PC <= 0x0000_4180 on IntReq, 0x0000_3000 on reset.
- stall, no IntReq: all F/D registers hold, including D_ExcCode and D_BD.
- D_eret, no stall: D_instr <= 0, D_ExcCode <= 0, D_BD <= 0, D_PC <= PC; eret has no delay slot.
- normal: D_PC <= PC, D_instr <= IM_instr or 0 on fault, D_ExcCode <= 4 or 0, D_BD <= F_BD.
REQ-018 SHALL give a latency of exactly one cycle from PC presentation to D_* visibility when not stalled.
REQ-019 SHALL keep a faulting fetch in flight: ExcCode reaches D, PC keeps following npc until IntReq.
REQ-020 SHALL use unsigned 32-bit PC arithmetic and range compares; wrap-around needs no special handling, out-of-range values fault per REQ-015.

Reset
REQ-021 SHALL, while reset is low at an edge: PC = 0x0000_3000, D_PC = 0x0000_3000, D_instr = 0, D_ExcCode = 0, D_BD = 0.
REQ-022 SHALL let reset override IntReq, stall and D_eret; the first fetch after release is from 0x0000_3000.

Structure
REQ-023 SHALL take 0x0000_3000 (reset vector), 0x0000_4180 (handler vector), the IM range bounds and ExcCode AdEL = 4 from the shared define.v package; NPC uses the same handler constant.
REQ-024 SHALL be split into one sub-module, fd_reg (the F/D pipeline register); PC register and fault check stay in fetch_unit.

Verification
REQ-025 SHALL test reset: reset low 2 cycles, then high with npc = PC+4 -> PC steps 0x3000, 0x3004, 0x3008; D_PC lags by one cycle.
REQ-026 SHALL test stall: stall = 1 for 3 cycles at PC = 0x3010 -> PC and all D_* frozen; on release PC <= npc next edge.
REQ-027 SHALL test IntReq during stall: stall = 1, IntReq = 1 at PC = 0x3020 -> PC = 0x4180, D_instr = 0, D_PC = 0x4180, D_BD = 0.
REQ-028 SHALL test misaligned fetch: npc = 0x3002 -> next cycle D_ExcCode = 4, D_instr = 0; same for npc = 0x7000.
REQ-029 SHALL test delay slot: D_is_branch = 1 at PC = 0x3040 -> D_BD = 1, D_PC = 0x3040; D_eret = 1 at PC = 0x3050 -> D_instr = 0, D_BD = 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants, F/D register payload type and fetch fault check.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VEC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;
  localparam logic [31:0] IM_LO       = 32'h0000_3000;
  localparam logic [31:0] IM_HI       = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE    = 5'd0;
  localparam logic [4:0]  EXC_ADEL    = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc_code;
    logic        bd;
  } fd_t;

  // AdEL on fetch: misaligned or outside the instruction memory window.
  function automatic logic fetch_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: pipeline control in, IM data in, F-stage PC and F/D register out.
interface fetch_unit_if;
  logic [31:0] npc;
  logic        stall;
  logic        IntReq;
  logic        D_eret;
  logic        D_is_branch;
  logic [31:0] IM_instr;
  logic [31:0] PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic [4:0]  D_ExcCode;
  logic        D_BD;

  modport slave (
    input  npc, stall, IntReq, D_eret, D_is_branch, IM_instr,
    output PC, D_PC, D_instr, D_ExcCode, D_BD
  );

  modport master (
    output npc, stall, IntReq, D_eret, D_is_branch, IM_instr,
    input  PC, D_PC, D_instr, D_ExcCode, D_BD
  );
endinterface

// File: rtl/fetch_unit_fd_reg.sv
// F/D pipeline register: flush on reset/interrupt, hold on stall, squash on eret.
module fd_reg
  import fetch_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic int_req,
  input  logic stall,
  input  logic eret,
  input  fd_t  f_s,
  output fd_t  d_r
);

  // F/D capture; eret has no delay slot, so its successor is squashed but keeps its PC.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_r <= '{pc: RESET_VEC, instr: 32'h0000_0000, exc_code: EXC_NONE, bd: 1'b0};
    end else if (int_req) begin
      d_r <= '{pc: HANDLER_VEC, instr: 32'h0000_0000, exc_code: EXC_NONE, bd: 1'b0};
    end else if (stall) begin
      d_r <= d_r;
    end else if (eret) begin
      d_r <= '{pc: f_s.pc, instr: 32'h0000_0000, exc_code: EXC_NONE, bd: 1'b0};
    end else begin
      d_r <= f_s;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, fetch address fault check and the F/D register.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  logic [31:0] pc_r;
  logic        fault_s;
  fd_t         f_s;
  fd_t         d_s;

  // PC update: interrupt redirect wins over a stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r <= RESET_VEC;
    end else if (bus.IntReq) begin
      pc_r <= HANDLER_VEC;
    end else if (bus.stall) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= bus.npc;
    end
  end

  // Faulting fetches carry a nop and the AdEL code down the pipe.
  always_comb begin
    fault_s  = fetch_fault(pc_r);
    f_s.pc   = pc_r;
    f_s.bd   = bus.D_is_branch;
    if (fault_s) begin
      f_s.instr    = 32'h0000_0000;
      f_s.exc_code = EXC_ADEL;
    end else begin
      f_s.instr    = bus.IM_instr;
      f_s.exc_code = EXC_NONE;
    end
  end

  fd_reg u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .int_req (bus.IntReq),
    .stall   (bus.stall),
    .eret    (bus.D_eret),
    .f_s     (f_s),
    .d_r     (d_s)
  );

  assign bus.PC        = pc_r;
  assign bus.D_PC      = d_s.pc;
  assign bus.D_instr   = d_s.instr;
  assign bus.D_ExcCode = d_s.exc_code;
  assign bus.D_BD      = d_s.bd;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [31:0] pc_m, dpc_m, di_m;
  logic [4:0]  de_m;
  logic        dbd_m;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0] + 16'h1357};
  endfunction

  assign bus.IM_instr = im_word(bus.PC);

  function automatic logic faults(input logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PC"},        bus.PC,                 pc_m);
    chk({tag, ".D_PC"},      bus.D_PC,               dpc_m);
    chk({tag, ".D_instr"},   bus.D_instr,            di_m);
    chk({tag, ".D_ExcCode"}, {27'd0, bus.D_ExcCode}, {27'd0, de_m});
    chk({tag, ".D_BD"},      {31'd0, bus.D_BD},      {31'd0, dbd_m});
  endtask

  // One clock: drive inputs, predict from the behavioural rules, compare after the edge.
  task automatic step(input string tag, input logic rst_v, input logic int_v,
                      input logic stall_v, input logic eret_v, input logic br_v,
                      input logic [31:0] npc_v);
    logic [31:0] pc_n, dpc_n, di_n;
    logic [4:0]  de_n;
    logic        dbd_n;
    reset           = rst_v;
    bus.IntReq      = int_v;
    bus.stall       = stall_v;
    bus.D_eret      = eret_v;
    bus.D_is_branch = br_v;
    bus.npc         = npc_v;
    pc_n = pc_m; dpc_n = dpc_m; di_n = di_m; de_n = de_m; dbd_n = dbd_m;
    if (!rst_v) begin
      pc_n = 32'h3000; dpc_n = 32'h3000; di_n = 32'd0; de_n = 5'd0; dbd_n = 1'b0;
    end else if (int_v) begin
      pc_n = 32'h4180; dpc_n = 32'h4180; di_n = 32'd0; de_n = 5'd0; dbd_n = 1'b0;
    end else if (stall_v) begin
      pc_n = pc_m;
    end else begin
      pc_n  = npc_v;
      dpc_n = pc_m;
      if (eret_v) begin
        di_n = 32'd0; de_n = 5'd0; dbd_n = 1'b0;
      end else begin
        di_n  = faults(pc_m) ? 32'd0 : im_word(pc_m);
        de_n  = faults(pc_m) ? 5'd4 : 5'd0;
        dbd_n = br_v;
      end
    end
    @(posedge clk);
    #1;
    pc_m = pc_n; dpc_m = dpc_n; di_m = di_n; de_m = de_n; dbd_m = dbd_n;
    check_all(tag);
  endtask

  task automatic run(input string tag, input logic [31:0] npc_v);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, npc_v);
  endtask

  function automatic logic [31:0] rand_npc(input logic [31:0] cur);
    logic [31:0] edges [4];
    edges[0] = 32'h0000_2FFC; edges[1] = 32'h0000_3000;
    edges[2] = 32'h0000_6FFC; edges[3] = 32'h0000_7000;
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return cur + 32'd4;
      4:          return 32'h0000_3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
      5:          return edges[$urandom_range(0, 3)];
      6:          return $urandom;
      default:    return cur + 32'd2;
    endcase
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; bus.IntReq = 1'b0; bus.stall = 1'b0; bus.D_eret = 1'b0;
    bus.D_is_branch = 1'b0; bus.npc = 32'h0;
    pc_m = 32'h3000; dpc_m = 32'h3000; di_m = 32'd0; de_m = 5'd0; dbd_m = 1'b0;

    // Reset, overriding every other control, then sequential fetch.
    step("rst0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
    step("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_5000);
    chk("rst.PC_vec", bus.PC, 32'h0000_3000);
    run("seq0", pc_m + 32'd4);
    chk("seq0.D_PC_lag", bus.D_PC, 32'h0000_3000);
    run("seq1", pc_m + 32'd4);
    chk("seq1.PC", bus.PC, 32'h0000_3008);
    run("seq2", pc_m + 32'd4);
    run("seq3", pc_m + 32'd4);
    chk("seq3.PC", bus.PC, 32'h0000_3010);

    // Stall at 0x3010 for three cycles, then release.
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3100);
    chk("stall.PC_frozen", bus.PC, 32'h0000_3010);
    run("unstall", 32'h0000_3020);
    chk("unstall.PC", bus.PC, 32'h0000_3020);

    // Interrupt while stalled at 0x3020.
    step("int_stall", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3024);
    chk("int.PC", bus.PC, 32'h0000_4180);
    chk("int.D_PC", bus.D_PC, 32'h0000_4180);

    // Fetch faults: misaligned and past the top of IM.
    run("mis_pc", 32'h0000_3002);
    run("mis_d", 32'h0000_3004);
    chk("mis.ExcCode", {27'd0, bus.D_ExcCode}, 32'd4);
    run("hi_pc", 32'h0000_7000);
    run("hi_d", 32'h0000_7004);
    chk("hi.ExcCode", {27'd0, bus.D_ExcCode}, 32'd4);
    run("lo_pc", 32'h0000_2FFC);
    run("top_pc", 32'h0000_6FFC);
    run("top_d", 32'h0000_3040);

    // Delay-slot flag and eret squash.
    step("br", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3050);
    chk("br.D_BD", {31'd0, bus.D_BD}, 32'd1);
    chk("br.D_PC", bus.D_PC, 32'h0000_3040);
    step("eret", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3054);
    chk("eret.D_instr", bus.D_instr, 32'd0);
    step("eret_stall", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3060);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 31) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0),
           rand_npc(pc_m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
